// File: rtl/riscv_pkg.sv
// Shared RV32I decode encodings: opcodes, ALU/result/immediate selects
// and the bundled main-decoder control word.
package riscv_pkg;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } result_src_e;

   typedef enum logic [1:0] {
      IMM_I = 2'b00,
      IMM_S = 2'b01,
      IMM_B = 2'b10,
      IMM_J = 2'b11
   } imm_src_e;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } alu_op_e;

   typedef struct packed {
      logic        reg_write;
      logic        mem_write;
      logic        alu_src;
      logic        branch;
      logic        jump;
      result_src_e result_src;
      imm_src_e    imm_src;
      alu_op_e     alu_op;
   } ctrl_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch/hazard/writeback inputs and decoded outputs of the decode stage;
// master drives the fetch side, slave is the decode stage itself.
interface decode_stage_if #(
   parameter int XLEN = 32
);
   logic            Stall_D;
   logic            Flush_D;
   logic [31:0]     Instr_F;
   logic [XLEN-1:0] PC_F;
   logic [XLEN-1:0] PCPlus4_F;
   logic            RegWrite_W;
   logic [4:0]      Rd_W;
   logic [XLEN-1:0] Result_W;

   logic            RegWrite_D;
   logic            MemWrite_D;
   logic            ALUSrc_D;
   logic            Branch_D;
   logic            Jump_D;
   logic [1:0]      ResultSrc_D;
   logic [2:0]      ALUControl_D;
   logic [XLEN-1:0] PC_D;
   logic [XLEN-1:0] PCPlus4_D;
   logic [XLEN-1:0] RD1_D;
   logic [XLEN-1:0] RD2_D;
   logic [XLEN-1:0] Imm_Ext_D;
   logic [4:0]      Rs1_D;
   logic [4:0]      Rs2_D;
   logic [4:0]      Rd_D;

   modport master (
      output Stall_D, Flush_D, Instr_F, PC_F, PCPlus4_F,
             RegWrite_W, Rd_W, Result_W,
      input  RegWrite_D, MemWrite_D, ALUSrc_D, Branch_D, Jump_D,
             ResultSrc_D, ALUControl_D, PC_D, PCPlus4_D, RD1_D, RD2_D,
             Imm_Ext_D, Rs1_D, Rs2_D, Rd_D
   );

   modport slave (
      input  Stall_D, Flush_D, Instr_F, PC_F, PCPlus4_F,
             RegWrite_W, Rd_W, Result_W,
      output RegWrite_D, MemWrite_D, ALUSrc_D, Branch_D, Jump_D,
             ResultSrc_D, ALUControl_D, PC_D, PCPlus4_D, RD1_D, RD2_D,
             Imm_Ext_D, Rs1_D, Rs2_D, Rd_D
   );
endinterface

// File: rtl/register_file.sv
// 31 x XLEN register file, x0 hardwired to zero, with same-cycle
// writeback-to-read bypass on both read ports.
module register_file #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            we_i,
   input  logic [4:0]      wa_i,
   input  logic [XLEN-1:0] wd_i,
   input  logic [4:0]      ra1_i,
   input  logic [4:0]      ra2_i,
   output logic [XLEN-1:0] rd1_o,
   output logic [XLEN-1:0] rd2_o
);

   logic [XLEN-1:0] regs_q [1:31];
   logic            wr_en;

   assign wr_en = we_i && (wa_i != '0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned i = 1; i < 32; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en) begin
         regs_q[wa_i] <= wd_i;
      end
   end

   // wr_en already excludes x0, so a bypass never overrides the zero read
   always_comb begin
      rd1_o = '0;
      if (wr_en && (wa_i == ra1_i)) begin
         rd1_o = wd_i;
      end else if (ra1_i != '0) begin
         rd1_o = regs_q[ra1_i];
      end
   end

   always_comb begin
      rd2_o = '0;
      if (wr_en && (wa_i == ra2_i)) begin
         rd2_o = wd_i;
      end else if (ra2_i != '0) begin
         rd2_o = regs_q[ra2_i];
      end
   end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID register, register file, main/ALU decoders
// and immediate extender feeding the ID/EX register.
module decode_stage
   import riscv_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input logic           clk,
   input logic           rst,
   decode_stage_if.slave bus
);

   logic [31:0]     instr_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pcp4_q;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic            funct7b5;
   ctrl_t           ctrl;
   alu_ctrl_e       alu_ctrl;
   logic [XLEN-1:0] imm_ext;

   // Reset and flush both load a bubble; flush outranks stall
   always_ff @(posedge clk) begin
      if (rst || bus.Flush_D) begin
         instr_q <= '0;
         pc_q    <= RESET_PC;
         pcp4_q  <= RESET_PC + XLEN'(4);
      end else if (!bus.Stall_D) begin
         instr_q <= bus.Instr_F;
         pc_q    <= bus.PC_F;
         pcp4_q  <= bus.PCPlus4_F;
      end
   end

   assign opcode   = instr_q[6:0];
   assign funct3   = instr_q[14:12];
   assign funct7b5 = instr_q[30];

   always_comb begin
      ctrl = '0;
      case (opcode)
         OP_LW: begin
            ctrl.reg_write  = 1'b1;
            ctrl.alu_src    = 1'b1;
            ctrl.result_src = RES_MEM;
            ctrl.imm_src    = IMM_I;
            ctrl.alu_op     = ALUOP_ADD;
         end
         OP_SW: begin
            ctrl.mem_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.imm_src   = IMM_S;
            ctrl.alu_op    = ALUOP_ADD;
         end
         OP_R: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         OP_I: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.imm_src   = IMM_I;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         OP_BEQ: begin
            ctrl.branch  = 1'b1;
            ctrl.imm_src = IMM_B;
            ctrl.alu_op  = ALUOP_SUB;
         end
         OP_JAL: begin
            ctrl.reg_write  = 1'b1;
            ctrl.jump       = 1'b1;
            ctrl.result_src = RES_PC4;
            ctrl.imm_src    = IMM_J;
         end
         default: ;
      endcase
   end

   always_comb begin
      alu_ctrl = ALU_ADD;
      case (ctrl.alu_op)
         ALUOP_SUB: alu_ctrl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               3'b000:  alu_ctrl = (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_ctrl = ALU_SLT;
               3'b110:  alu_ctrl = ALU_OR;
               3'b111:  alu_ctrl = ALU_AND;
               default: alu_ctrl = ALU_ADD;
            endcase
         end
         default: ;
      endcase
   end

   always_comb begin
      imm_ext = '0;
      case (ctrl.imm_src)
         IMM_I: imm_ext = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
         IMM_S: imm_ext = {{(XLEN-12){instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
         IMM_B: imm_ext = {{(XLEN-12){instr_q[31]}}, instr_q[7], instr_q[30:25],
                           instr_q[11:8], 1'b0};
         IMM_J: imm_ext = {{(XLEN-20){instr_q[31]}}, instr_q[19:12], instr_q[20],
                           instr_q[30:21], 1'b0};
         default: ;
      endcase
   end

   register_file #(
      .XLEN(XLEN)
   ) u_regfile (
      .clk_i (clk),
      .rst_i (rst),
      .we_i  (bus.RegWrite_W),
      .wa_i  (bus.Rd_W),
      .wd_i  (bus.Result_W),
      .ra1_i (instr_q[19:15]),
      .ra2_i (instr_q[24:20]),
      .rd1_o (bus.RD1_D),
      .rd2_o (bus.RD2_D)
   );

   assign bus.RegWrite_D   = ctrl.reg_write;
   assign bus.MemWrite_D   = ctrl.mem_write;
   assign bus.ALUSrc_D     = ctrl.alu_src;
   assign bus.Branch_D     = ctrl.branch;
   assign bus.Jump_D       = ctrl.jump;
   assign bus.ResultSrc_D  = ctrl.result_src;
   assign bus.ALUControl_D = alu_ctrl;
   assign bus.Imm_Ext_D    = imm_ext;
   assign bus.PC_D         = pc_q;
   assign bus.PCPlus4_D    = pcp4_q;
   assign bus.Rs1_D        = instr_q[19:15];
   assign bus.Rs2_D        = instr_q[24:20];
   assign bus.Rd_D         = instr_q[11:7];

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios followed by
// randomized traffic, all checked against a behavioural pipeline/regfile model.
module tb_decode_stage;

   localparam logic [31:0] RPC = 32'h0000_0100;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   logic [31:0] m_instr;
   logic [31:0] m_pc;
   logic [31:0] m_pcp4;
   logic [31:0] m_rf [32];

   decode_stage_if #(.XLEN(32)) bus ();

   decode_stage #(
      .XLEN     (32),
      .RESET_PC (RPC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] alu_of_funct(input logic [2:0] f3, input logic sub);
      case (f3)
         3'b000:  return sub ? 3'd1 : 3'd0;
         3'b010:  return 3'd5;
         3'b110:  return 3'd3;
         3'b111:  return 3'd2;
         default: return 3'd0;
      endcase
   endfunction

   task automatic check_model();
      logic [31:0] i;
      logic        e_rw, e_mw, e_as, e_br, e_j;
      logic [1:0]  e_rs;
      logic [2:0]  e_alu;
      logic [31:0] e_imm, e_rd1, e_rd2;
      logic [4:0]  rs1, rs2;
      i = m_instr;
      rs1 = i[19:15];
      rs2 = i[24:20];
      {e_rw, e_mw, e_as, e_br, e_j} = '0;
      e_rs  = 2'd0;
      e_alu = 3'd0;
      e_imm = {{20{i[31]}}, i[31:20]};
      case (i[6:0])
         7'h03: begin e_rw = 1; e_as = 1; e_rs = 2'd1; end
         7'h23: begin e_mw = 1; e_as = 1; e_imm = {{20{i[31]}}, i[31:25], i[11:7]}; end
         7'h33: begin e_rw = 1; e_alu = alu_of_funct(i[14:12], i[30]); end
         7'h13: begin e_rw = 1; e_as = 1; e_alu = alu_of_funct(i[14:12], 1'b0); end
         7'h63: begin
            e_br = 1; e_alu = 3'd1;
            e_imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
         end
         7'h6F: begin
            e_rw = 1; e_j = 1; e_rs = 2'd2;
            e_imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
         end
         default: ;
      endcase
      e_rd1 = (bus.RegWrite_W && bus.Rd_W != 0 && bus.Rd_W == rs1) ? bus.Result_W : m_rf[rs1];
      e_rd2 = (bus.RegWrite_W && bus.Rd_W != 0 && bus.Rd_W == rs2) ? bus.Result_W : m_rf[rs2];
      chk("RegWrite_D", 32'(bus.RegWrite_D), 32'(e_rw));
      chk("MemWrite_D", 32'(bus.MemWrite_D), 32'(e_mw));
      chk("ALUSrc_D", 32'(bus.ALUSrc_D), 32'(e_as));
      chk("Branch_D", 32'(bus.Branch_D), 32'(e_br));
      chk("Jump_D", 32'(bus.Jump_D), 32'(e_j));
      chk("ResultSrc_D", 32'(bus.ResultSrc_D), 32'(e_rs));
      chk("ALUControl_D", 32'(bus.ALUControl_D), 32'(e_alu));
      chk("Imm_Ext_D", bus.Imm_Ext_D, e_imm);
      chk("PC_D", bus.PC_D, m_pc);
      chk("PCPlus4_D", bus.PCPlus4_D, m_pcp4);
      chk("RD1_D", bus.RD1_D, e_rd1);
      chk("RD2_D", bus.RD2_D, e_rd2);
      chk("Rs1_D", 32'(bus.Rs1_D), 32'(rs1));
      chk("Rs2_D", 32'(bus.Rs2_D), 32'(rs2));
      chk("Rd_D", 32'(bus.Rd_D), 32'(i[11:7]));
   endtask

   task automatic model_edge();
      if (rst) begin
         m_instr = '0;
         m_pc    = RPC;
         m_pcp4  = RPC + 32'd4;
         for (int r = 0; r < 32; r++) m_rf[r] = '0;
      end else begin
         if (bus.Flush_D) begin
            m_instr = '0;
            m_pc    = RPC;
            m_pcp4  = RPC + 32'd4;
         end else if (!bus.Stall_D) begin
            m_instr = bus.Instr_F;
            m_pc    = bus.PC_F;
            m_pcp4  = bus.PCPlus4_F;
         end
         if (bus.RegWrite_W && bus.Rd_W != 0) m_rf[bus.Rd_W] = bus.Result_W;
      end
   endtask

   task automatic set_in(input logic [31:0] instr, input logic stall, input logic flush,
                         input logic rw, input logic [4:0] rd, input logic [31:0] res,
                         input logic r);
      logic [31:0] pc;
      pc = $urandom() & 32'hFFFF_FFFC;
      rst            = r;
      bus.Instr_F    = instr;
      bus.PC_F       = pc;
      bus.PCPlus4_F  = pc + 32'd4;
      bus.Stall_D    = stall;
      bus.Flush_D    = flush;
      bus.RegWrite_W = rw;
      bus.Rd_W       = rd;
      bus.Result_W   = res;
      #2;
   endtask

   task automatic cycle();
      check_model();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   initial begin
      logic [31:0] held_pc;
      logic [31:0] rnd;
      logic [6:0]  ops [8];
      logic [6:0]  op;
      checks   = 0;
      failures = 0;
      ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h00, 7'h37};

      set_in(32'h0, 0, 0, 0, 5'd0, 32'h0, 1'b1);
      @(posedge clk);
      model_edge();
      #1;

      // reset state
      set_in(32'h0050_0093, 0, 0, 0, 5'd0, 32'h0, 1'b0);
      chk("rst_PC_D", bus.PC_D, RPC);
      chk("rst_PCPlus4_D", bus.PCPlus4_D, RPC + 32'd4);
      chk("rst_ctrl", 32'({bus.RegWrite_D, bus.MemWrite_D, bus.ALUSrc_D, bus.Branch_D,
                           bus.Jump_D, bus.ResultSrc_D, bus.ALUControl_D}), 32'd0);
      chk("rst_Imm", bus.Imm_Ext_D, 32'd0);
      cycle();

      // addi x1,x0,5 decoded
      set_in(32'h0052_8333, 0, 0, 0, 5'd0, 32'h0, 1'b0);
      chk("addi_RegWrite", 32'(bus.RegWrite_D), 32'd1);
      chk("addi_ALUSrc", 32'(bus.ALUSrc_D), 32'd1);
      chk("addi_ALUControl", 32'(bus.ALUControl_D), 32'd0);
      chk("addi_Imm", bus.Imm_Ext_D, 32'd5);
      chk("addi_Rd", 32'(bus.Rd_D), 32'd1);
      cycle();

      // add x6,x5,x5 with same-cycle writeback of x5
      set_in(32'h0, 0, 0, 1, 5'd5, 32'hDEAD_BEEF, 1'b0);
      chk("bypass_RD1", bus.RD1_D, 32'hDEAD_BEEF);
      chk("bypass_RD2", bus.RD2_D, 32'hDEAD_BEEF);
      cycle();
      set_in(32'hFE00_0EE3, 0, 0, 1, 5'd0, 32'hFFFF_FFFF, 1'b0);
      chk("x0_RD1", bus.RD1_D, 32'd0);
      cycle();

      set_in(32'hFFDF_F0EF, 0, 0, 0, 5'd0, 32'h0, 1'b0);
      chk("beq_Branch", 32'(bus.Branch_D), 32'd1);
      chk("beq_ALUControl", 32'(bus.ALUControl_D), 32'd1);
      chk("beq_Imm", bus.Imm_Ext_D, 32'hFFFF_FFFC);
      cycle();
      set_in(32'h0021_A423, 0, 0, 0, 5'd0, 32'h0, 1'b0);
      chk("jal_Jump", 32'(bus.Jump_D), 32'd1);
      chk("jal_ResultSrc", 32'(bus.ResultSrc_D), 32'd2);
      chk("jal_Imm", bus.Imm_Ext_D, 32'hFFFF_FFFC);
      cycle();

      // sw held across a 3-cycle stall, then flush beats stall
      held_pc = bus.PC_D;
      for (int k = 0; k < 3; k++) begin
         set_in($urandom(), 1, 0, 1, 5'd2, $urandom(), 1'b0);
         chk("stall_PC", bus.PC_D, held_pc);
         chk("sw_MemWrite", 32'(bus.MemWrite_D), 32'd1);
         chk("sw_RegWrite", 32'(bus.RegWrite_D), 32'd0);
         chk("sw_Imm", bus.Imm_Ext_D, 32'd8);
         cycle();
      end
      set_in($urandom(), 1, 1, 0, 5'd0, 32'h0, 1'b0);
      cycle();
      set_in(32'h4031_00B3, 0, 0, 0, 5'd0, 32'h0, 1'b0);
      chk("flush_PC", bus.PC_D, RPC);
      chk("flush_ctrl", 32'({bus.RegWrite_D, bus.MemWrite_D, bus.ALUSrc_D, bus.Branch_D,
                             bus.Jump_D, bus.ResultSrc_D, bus.ALUControl_D}), 32'd0);
      cycle();
      set_in(32'h0, 0, 0, 0, 5'd0, 32'h0, 1'b0);
      chk("sub_ALUControl", 32'(bus.ALUControl_D), 32'd1);
      cycle();

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         rnd = $urandom();
         op  = ops[$urandom_range(7)];
         if (op == 7'h37 && rnd[0]) op = rnd[7:1];
         set_in({rnd[31:7], op}, ($urandom_range(5) == 0), ($urandom_range(9) == 0),
                ($urandom_range(1) == 1), 5'($urandom_range(31)), $urandom(),
                ($urandom_range(60) == 0));
         cycle();
      end

      // reset with a simultaneous write to x7
      set_in(32'h0, 0, 0, 1, 5'd7, 32'h0000_5555, 1'b0);
      cycle();
      set_in(32'h0003_8013, 1, 1, 1, 5'd7, 32'h0000_1234, 1'b1);
      cycle();
      set_in(32'h0003_8013, 0, 0, 0, 5'd0, 32'h0, 1'b0);
      chk("rst2_PC_D", bus.PC_D, RPC);
      chk("rst2_PCPlus4_D", bus.PCPlus4_D, RPC + 32'd4);
      chk("rst2_ctrl", 32'({bus.RegWrite_D, bus.MemWrite_D, bus.ALUSrc_D, bus.Branch_D,
                            bus.Jump_D, bus.ResultSrc_D, bus.ALUControl_D}), 32'd0);
      chk("rst2_regs", {bus.Imm_Ext_D[15:0], 1'b0, bus.Rs1_D, bus.Rs2_D, bus.Rd_D}, 32'd0);
      cycle();
      set_in(32'h0, 0, 0, 0, 5'd0, 32'h0, 1'b0);
      chk("rst2_x7", bus.RD1_D, 32'd0);
      cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
